trace_capture_fifo: RTL and testbench
=====================================

Name: trace_capture_fifo

Overview:
- Downstream observer of the 16-bit single-cycle MIPS core; consumes the core's per-cycle pc_out and alu_result and buffers them as execution trace records.
- Records drain through a valid/ready port to a slower consumer, such as a bench checker or a UART dumper.
- Also detects program halt, defined as PC stuck for STALL_LIMIT consecutive cycles, and flags buffer overflow.

Parameters:
- DEPTH, 16, number of trace entries; must be a power of two ≥ 2.
- PC_W, 16, program counter width.
- DATA_W, 16, ALU result width.
- STALL_LIMIT, 4, consecutive repeated-PC samples that declare halt (≥ 1).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high; clears all state.
- cap_en  in  1  capture enable; a sample is taken on every clock edge where it is high.
- pc_in  in  PC_W  core pc_out.
- alu_in  in  DATA_W  core alu_result.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts the head entry.
- out_pc  out  PC_W  head entry PC.
- out_alu  out  DATA_W  head entry ALU result.
- count  out  log2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; a sample was dropped because the FIFO was full.
- dropped  out  16  dropped-sample counter, saturating at 16'hFFFF.
- halted  out  1  sticky halt flag.

Behaviour:
- Reset (synchronous, has priority over everything):
  - count = 0, out_valid = 0, out_pc = 0, out_alu = 0.
  - overflow = 0, dropped = 0, halted = 0.
  - stall counter = 0, pc_prev_valid = 0.
  - FIFO contents are logically discarded.
  - Reset asserted mid-drain behaves identically to reset at power-up.
- push_req = cap_en & ~halted.
- pop = out_valid & out_ready.
- FIFO organisation:
  - First-word-fall-through.
  - out_valid = (count != 0).
  - out_pc/out_alu always show the head entry and are held stable while out_valid=1 and out_ready=0.
  - Outputs read 0 when empty.
- Latency: a sample pushed at edge N is visible on out_* with out_valid=1 after edge N (the following cycle) if the FIFO was empty.
- Push/pop cases on a single edge:
  - Push only: write at the tail; count+1.
  - Pop only: advance the head; count−1.
  - Push and pop with count in 1..DEPTH: both take effect; count unchanged. This includes the full case, where the pop frees the slot.
  - Push and pop with count=0: pop is not possible because out_valid=0; the push succeeds and count becomes 1.
  - Push with count=DEPTH and no pop: sample dropped, contents unchanged, overflow←1, dropped←dropped+1 unless already 16'hFFFF.
- Pointers:
  - Head and tail are log2(DEPTH)-bit and wrap modulo DEPTH.
  - count is tracked separately so that full and empty are unambiguous.
- Halt detection (only on edges where cap_en=1):
  - If pc_prev_valid and pc_in == pc_prev: stall_cnt+1, saturating at STALL_LIMIT. Otherwise stall_cnt←0.
  - pc_prev←pc_in; pc_prev_valid←1.
  - halted←1 on the edge where stall_cnt becomes STALL_LIMIT.
  - That sample is still pushed, because halted was 0 at that edge.
  - From the next edge on, no further pushes occur. halted stays set until reset.
  - When cap_en=0, stall_cnt, pc_prev and pc_prev_valid hold their values.
- Draining continues normally after halt.

Test Plan:
- Reset, then cap_en=1 for 3 cycles with (pc,alu) = (0,5), (2,7), (4,9) and out_ready=0 → count=3; out_valid=1; out_pc=0, out_alu=5 held. Then out_ready=1 → records 0/5, 2/7, 4/9 emerge in order over 3 cycles, then out_valid=0 and count=0.
- Fill 16 distinct PCs with out_ready=0, then push 3 more → count=16, overflow=1, dropped=3. Draining returns the first 16 PCs unchanged.
- At count=16 with out_ready=1 and cap_en=1 for 1 cycle → count stays 16, overflow=0, the new sample lands at the tail. Also verifies pointer wrap after 20+ push/pop cycles.
- Repeat pc_in=0x0010 for 5 edges with STALL_LIMIT=4 → halted=1 after the 5th edge. Exactly 5 entries with PC 0x0010 are in the FIFO; further cap_en cycles add nothing.
- Empty FIFO with cap_en=1 and out_ready=1 on the same edge → count=1, out_valid=1 the next cycle, no spurious pop.
- Assert reset for 1 cycle mid-drain at count=7 with overflow=1 and halted=1 → the next cycle shows count=0, out_valid=0, overflow=0, dropped=0, halted=0.

Source files
------------

// File: rtl/trace_capture_fifo.sv
// -----------------------------------------------------------------------------
// trace_capture_fifo
//
// Captures per-cycle execution trace records (PC, ALU result) from a 16-bit
// single-cycle MIPS core into a first-word-fall-through FIFO. A slower
// consumer drains the records over a valid/ready port. The block also flags
// program halt (PC unchanged for STALL_LIMIT consecutive repeats) and counts
// samples dropped because the buffer was full.
//
// Ports:
//   clk        in   rising-edge system clock
//   reset      in   synchronous active-high reset, clears all state
//   cap_en     in   capture enable; one sample per edge while high
//   pc_in      in   core pc_out
//   alu_in     in   core alu_result
//   out_valid  out  head entry available
//   out_ready  in   consumer accepts the head entry
//   out_pc     out  head entry PC (0 when empty)
//   out_alu    out  head entry ALU result (0 when empty)
//   count      out  current occupancy, 0..DEPTH
//   overflow   out  sticky: a sample was dropped because the FIFO was full
//   dropped    out  dropped-sample counter, saturates at 16'hFFFF
//   halted     out  sticky halt flag; stops further captures until reset
// -----------------------------------------------------------------------------
module trace_capture_fifo #(
  parameter int DEPTH       = 16,
  parameter int PC_W        = 16,
  parameter int DATA_W      = 16,
  parameter int STALL_LIMIT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cap_en,
  input  logic [PC_W-1:0]            pc_in,
  input  logic [DATA_W-1:0]          alu_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [DATA_W-1:0]          out_alu,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [15:0]                dropped,
  output logic                       halted
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STALL_LIMIT + 1);

  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT);

  // Trace storage
  logic [PC_W-1:0]   r_mem_pc  [DEPTH];
  logic [DATA_W-1:0] r_mem_alu [DEPTH];

  // FIFO control
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  // Status
  logic          r_overflow;
  logic [15:0]   r_dropped;
  logic          r_halted;

  // Halt detection
  logic [SW-1:0]   r_stall_cnt;
  logic [PC_W-1:0] r_pc_prev;
  logic            r_pc_prev_valid;

  logic          w_out_valid;
  logic          w_full;
  logic          w_push_req;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [SW-1:0] w_stall_next;

  assign w_out_valid = (r_count != '0);
  assign w_full      = (r_count == FULL_CNT);
  assign w_push_req  = cap_en & ~r_halted;
  assign w_pop       = w_out_valid & out_ready;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign w_push      = w_push_req & (~w_full | w_pop);
  assign w_drop      = w_push_req & w_full & ~w_pop;

  // NOTE: combinational blocks assign a default first so no path leaves the
  // output unassigned, which would otherwise infer a latch.
  always_comb begin
    w_stall_next = '0;
    if (r_pc_prev_valid && (pc_in == r_pc_prev)) begin
      w_stall_next = (r_stall_cnt == STALL_MAX) ? STALL_MAX
                                                : r_stall_cnt + SW'(1);
    end
  end

  // NOTE: the storage array carries no reset; count and the pointers decide
  // what is visible, so stale contents after reset are never presented.
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem_pc[r_tail]  <= pc_in;
      r_mem_alu[r_tail] <= alu_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head          <= '0;
      r_tail          <= '0;
      r_count         <= '0;
      r_overflow      <= 1'b0;
      r_dropped       <= '0;
      r_halted        <= 1'b0;
      r_stall_cnt     <= '0;
      r_pc_prev       <= '0;
      r_pc_prev_valid <= 1'b0;
    end else begin
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_pop)  r_head <= r_head + AW'(1);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_dropped != 16'hFFFF) r_dropped <= r_dropped + 16'd1;
      end

      // Halt tracking advances only on captured edges; the sample on the
      // halting edge is still pushed because r_halted was clear.
      if (cap_en) begin
        r_stall_cnt     <= w_stall_next;
        r_pc_prev       <= pc_in;
        r_pc_prev_valid <= 1'b1;
        if (w_stall_next == STALL_MAX) r_halted <= 1'b1;
      end
    end
  end

  assign out_valid = w_out_valid;
  assign out_pc    = w_out_valid ? r_mem_pc[r_head]  : '0;
  assign out_alu   = w_out_valid ? r_mem_alu[r_head] : '0;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign dropped   = r_dropped;
  assign halted    = r_halted;

endmodule

// File: tb/tb_trace_capture_fifo.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for trace_capture_fifo (DEPTH=16,
// STALL_LIMIT=4). Inputs change 1 ns after a rising edge and outputs are
// sampled at that same point, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_trace_capture_fifo;

  logic        clk;
  logic        reset;
  logic        cap_en;
  logic [15:0] pc_in;
  logic [15:0] alu_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_pc;
  logic [15:0] out_alu;
  logic [4:0]  count;
  logic        overflow;
  logic [15:0] dropped;
  logic        halted;

  int checks = 0;
  int errors = 0;

  trace_capture_fifo #(
    .DEPTH(16), .PC_W(16), .DATA_W(16), .STALL_LIMIT(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cap_en    (cap_en),
    .pc_in     (pc_in),
    .alu_in    (alu_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_alu   (out_alu),
    .count     (count),
    .overflow  (overflow),
    .dropped   (dropped),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    cap_en    = 1'b0;
    out_ready = 1'b0;
    pc_in     = '0;
    alu_in    = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({count, out_valid, overflow, halted} !== 8'h00) begin
      errors++;
      $display("FAIL reset_status got cnt=%0d v=%0b ovf=%0b h=%0b exp all 0",
               count, out_valid, overflow, halted);
    end
    checks++;
    if ({out_pc, out_alu, dropped} !== 48'h0) begin
      errors++;
      $display("FAIL reset_data got pc=%h alu=%h drop=%h exp 0", out_pc, out_alu, dropped);
    end
  endtask

  task automatic test_basic();
    logic [15:0] pcs  [3] = '{16'h0000, 16'h0002, 16'h0004};
    logic [15:0] alus [3] = '{16'h0005, 16'h0007, 16'h0009};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cap_en = 1'b1;
      pc_in  = pcs[i];
      alu_in = alus[i];
      tick();
      if (i == 0) begin
        // One-cycle latency into an empty FIFO.
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 16'h0000 || out_alu !== 16'h0005) begin
          errors++;
          $display("FAIL basic_latency got v=%0b pc=%h alu=%h exp 1/0000/0005",
                   out_valid, out_pc, out_alu);
        end
      end
    end
    cap_en = 1'b0;
    tick();
    checks++;
    if (count !== 5'd3 || out_valid !== 1'b1 || out_pc !== 16'h0000 || out_alu !== 16'h0005) begin
      errors++;
      $display("FAIL basic_hold got cnt=%0d v=%0b pc=%h alu=%h exp 3/1/0000/0005",
               count, out_valid, out_pc, out_alu);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== pcs[i] || out_alu !== alus[i]) begin
        errors++;
        $display("FAIL basic_drain%0d got v=%0b pc=%h alu=%h exp 1/%h/%h",
                 i, out_valid, out_pc, out_alu, pcs[i], alus[i]);
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || count !== 5'd0 || out_pc !== 16'h0 || out_alu !== 16'h0) begin
      errors++;
      $display("FAIL basic_empty got v=%0b cnt=%0d pc=%h alu=%h exp 0/0/0/0",
               out_valid, count, out_pc, out_alu);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    cap_en = 1'b1;
    for (int i = 0; i < 19; i++) begin
      pc_in  = (i < 16) ? 16'h0100 + 16'(2 * i) : 16'h0200 + 16'(i);
      alu_in = 16'(i);
      tick();
    end
    cap_en = 1'b0;
    checks++;
    if (count !== 5'd16 || overflow !== 1'b1 || dropped !== 16'd3 || halted !== 1'b0) begin
      errors++;
      $display("FAIL ovf_status got cnt=%0d ovf=%0b drop=%0d h=%0b exp 16/1/3/0",
               count, overflow, dropped, halted);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (out_pc !== 16'h0100 + 16'(2 * i) || out_alu !== 16'(i)) begin
        errors++;
        $display("FAIL ovf_drain%0d got pc=%h alu=%h exp %h/%h",
                 i, out_pc, out_alu, 16'h0100 + 16'(2 * i), 16'(i));
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || count !== 5'd0) begin
      errors++;
      $display("FAIL ovf_empty got v=%0b cnt=%0d exp 0/0", out_valid, count);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    logic [31:0] head;
    do_reset();
    cap_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pc_in  = 16'h0300 + 16'(i);
      alu_in = 16'h1000 + 16'(i);
      q.push_back({pc_in, alu_in});
      tick();
    end
    checks++;
    if (count !== 5'd16) begin
      errors++;
      $display("FAIL b2b_fill got cnt=%0d exp 16", count);
    end
    // Full FIFO with simultaneous push and pop, continued long enough to
    // wrap both pointers.
    out_ready = 1'b1;
    for (int k = 0; k < 25; k++) begin
      pc_in  = (k == 0) ? 16'h03FF : 16'h0400 + 16'(k);
      alu_in = 16'h2000 + 16'(k);
      head = q.pop_front();
      q.push_back({pc_in, alu_in});
      checks++;
      if ({out_pc, out_alu} !== head) begin
        errors++;
        $display("FAIL b2b_head%0d got %h/%h exp %h/%h",
                 k, out_pc, out_alu, head[31:16], head[15:0]);
      end
      tick();
      checks++;
      if (count !== 5'd16 || overflow !== 1'b0 || dropped !== 16'd0) begin
        errors++;
        $display("FAIL b2b_full%0d got cnt=%0d ovf=%0b drop=%0d exp 16/0/0",
                 k, count, overflow, dropped);
      end
    end
    cap_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      head = q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || {out_pc, out_alu} !== head) begin
        errors++;
        $display("FAIL b2b_drain%0d got v=%0b %h/%h exp 1/%h/%h",
                 i, out_valid, out_pc, out_alu, head[31:16], head[15:0]);
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || count !== 5'd0) begin
      errors++;
      $display("FAIL b2b_empty got v=%0b cnt=%0d exp 0/0", out_valid, count);
    end
  endtask

  task automatic test_halt();
    do_reset();
    cap_en = 1'b1;
    pc_in  = 16'h0010;
    for (int e = 0; e < 5; e++) begin
      alu_in = 16'(e);
      tick();
      checks++;
      if (halted !== (e == 4)) begin
        errors++;
        $display("FAIL halt_edge%0d got h=%0b exp %0b", e + 1, halted, (e == 4));
      end
    end
    checks++;
    if (count !== 5'd5) begin
      errors++;
      $display("FAIL halt_count got %0d exp 5", count);
    end
    // Further captures after halt add nothing.
    for (int e = 0; e < 3; e++) begin
      pc_in  = 16'h0020 + 16'(e);
      alu_in = 16'h00AA;
      tick();
    end
    cap_en = 1'b0;
    checks++;
    if (count !== 5'd5 || halted !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL halt_frozen got cnt=%0d h=%0b ovf=%0b exp 5/1/0", count, halted, overflow);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 16'h0010 || out_alu !== 16'(i)) begin
        errors++;
        $display("FAIL halt_drain%0d got v=%0b pc=%h alu=%h exp 1/0010/%h",
                 i, out_valid, out_pc, out_alu, 16'(i));
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_after_drain got v=%0b h=%0b exp 0/1", out_valid, halted);
    end
  endtask

  task automatic test_empty_push_pop();
    do_reset();
    cap_en    = 1'b1;
    out_ready = 1'b1;
    pc_in     = 16'h0055;
    alu_in    = 16'h0066;
    tick();
    cap_en    = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (count !== 5'd1 || out_valid !== 1'b1 || out_pc !== 16'h0055 || out_alu !== 16'h0066) begin
      errors++;
      $display("FAIL empty_pushpop got cnt=%0d v=%0b pc=%h alu=%h exp 1/1/0055/0066",
               count, out_valid, out_pc, out_alu);
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    cap_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pc_in  = 16'h0500 + 16'(i);
      alu_in = 16'(i);
      tick();
    end
    // Five repeats of one PC while full: all dropped, halt on the fifth.
    pc_in = 16'h0600;
    for (int i = 0; i < 5; i++) tick();
    cap_en = 1'b0;
    checks++;
    if (overflow !== 1'b1 || dropped !== 16'd5 || halted !== 1'b1 || count !== 5'd16) begin
      errors++;
      $display("FAIL mid_setup got ovf=%0b drop=%0d h=%0b cnt=%0d exp 1/5/1/16",
               overflow, dropped, halted, count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if (count !== 5'd7 || out_pc !== 16'h0509) begin
      errors++;
      $display("FAIL mid_drain got cnt=%0d pc=%h exp 7/0509", count, out_pc);
    end
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (count !== 5'd0 || out_valid !== 1'b0 || overflow !== 1'b0 ||
        dropped !== 16'd0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got cnt=%0d v=%0b ovf=%0b drop=%0d h=%0b exp all 0",
               count, out_valid, overflow, dropped, halted);
    end
    // Capture resumes after reset clears the halt.
    cap_en = 1'b1;
    pc_in  = 16'h0077;
    alu_in = 16'h0088;
    tick();
    cap_en = 1'b0;
    checks++;
    if (count !== 5'd1 || out_pc !== 16'h0077 || out_alu !== 16'h0088) begin
      errors++;
      $display("FAIL mid_resume got cnt=%0d pc=%h alu=%h exp 1/0077/0088",
               count, out_pc, out_alu);
    end
  endtask

  initial begin
    reset     = 1'b1;
    cap_en    = 1'b0;
    out_ready = 1'b0;
    pc_in     = '0;
    alu_in    = '0;
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_halt();
    test_empty_push_pop();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
